// File: rtl/sys_bus_pkg.sv
// rtl/sys_bus_pkg.sv - shared constants and types for the system bus fabric
//
// Purpose:
//   Common definitions used by the system bus arbiter and its round-robin
//   picker. The address decoder selects a region from the top address nibble.
// Contents:
//   REGION_*        4-bit region codes carried in the top address nibble
//   ST_IDLE/ST_ADDR arbiter FSM state encoding
//   mid_t           1-bit master identifier (0 = CPU data port, 1 = boot/debug)
//   MID_M0/MID_M1   master identifier constants
package sys_bus_pkg;

  localparam logic [3:0] REGION_IMEM = 4'h0;
  localparam logic [3:0] REGION_DMEM = 4'h1;
  localparam logic [3:0] REGION_GPIO = 4'h2;
  localparam logic [3:0] REGION_UART = 4'h3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ADDR = 1'b1;

  typedef logic mid_t;

  localparam mid_t MID_M0 = 1'b0;
  localparam mid_t MID_M1 = 1'b1;

endpackage

// File: rtl/sys_arb_rr2.sv
// rtl/sys_arb_rr2.sv - combinational two-way round-robin pick
//
// Purpose:
//   Picks one of two requesters. A lone eligible requester always wins; when
//   both are eligible the one that did not win last time is chosen.
// Ports:
//   req[1:0]       raw request lines, bit n = master n
//   last_gnt       master granted most recently
//   lock_mask[1:0] per-master eligibility enable (1 = may be selected)
//   sel            selected master, meaningful only when valid=1
//   valid          at least one eligible requester
module sys_arb_rr2
  import sys_bus_pkg::*;
(
  input  logic [1:0] req,
  input  mid_t       last_gnt,
  input  logic [1:0] lock_mask,
  output mid_t       sel,
  output logic       valid
);

  logic [1:0] elig;

  always_comb begin
    elig  = req & lock_mask;
    valid = |elig;
    sel   = MID_M0;
    if (&elig) begin
      sel = ~last_gnt;
    end else if (elig[1]) begin
      sel = MID_M1;
    end
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// rtl/sys_bus_arbiter.sv - two-master round-robin arbiter for the system bus
//
// Purpose:
//   Shares the single-master system bus between the CPU data port (m0) and
//   the boot-loader/debug master (m1). Transfers are non-pipelined: a grant
//   drives the bus from registers for RD_LAT cycles, then the read data is
//   captured and returned to the owner with a one-cycle rvalid pulse.
// Parameters:
//   RD_LAT  cycles from first bus-drive cycle to bus_rdata sample (1..3)
//   AW, DW  address / data width
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mX_req/addr/wdata/wen      master X request, held until mX_gnt
//   mX_gnt                     one-cycle accept pulse
//   mX_rvalid, mX_rdata        one-cycle completion pulse, read data (0 on write)
//   mX_lock                    only with SYS_ARB_LOCK_EN: keep the bus for the
//                              next transfer of the same master
//   bus_addr/wdata/wen         registered drive to the address decoder
//   bus_rdata                  muxed read data from the decoder
// Configuration:
//   SYS_ARB_LOCK_EN  adds m0_lock/m1_lock and bus locking
module sys_bus_arbiter
  import sys_bus_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_wen,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_wen,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

`ifdef SYS_ARB_LOCK_EN
  input  logic          m0_lock,
  input  logic          m1_lock,
`endif

  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic          bus_wen,
  input  logic [DW-1:0] bus_rdata
);

  // Value of cnt during the final ADDR cycle; RD_LAT is limited to 1..3 so
  // a 2-bit counter is always wide enough.
  localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

  logic [0:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  mid_t          owner_q, owner_d;
  mid_t          last_gnt_q, last_gnt_d;
  // Direction of the transfer in flight; bus_wen only lasts one cycle so it
  // cannot be used to decide between read data and zero at completion.
  logic          wen_q, wen_d;

  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic          bus_wen_q, bus_wen_d;

  logic          m0_gnt_q, m0_gnt_d;
  logic          m1_gnt_q, m1_gnt_d;
  logic          m0_rvalid_q, m0_rvalid_d;
  logic          m1_rvalid_q, m1_rvalid_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;

  logic [1:0]    req_vec;
  logic [1:0]    lock_mask;
  mid_t          sel;
  logic          sel_valid;

`ifdef SYS_ARB_LOCK_EN
  logic          lock_q, lock_d;
  logic          lock_hold;

  // The lock only survives an arbitration in which the owner is still
  // requesting with lock asserted; otherwise the bus is released.
  always_comb begin
    lock_hold = 1'b0;
    if (lock_q) begin
      lock_hold = (owner_q == MID_M1) ? (m1_req && m1_lock) : (m0_req && m0_lock);
    end
    lock_mask = 2'b11;
    if (lock_hold) begin
      lock_mask = (owner_q == MID_M1) ? 2'b10 : 2'b01;
    end
  end
`else
  always_comb begin
    lock_mask = 2'b11;
  end
`endif

  assign req_vec = {m1_req, m0_req};

  sys_arb_rr2 u_rr (
    .req       (req_vec),
    .last_gnt  (last_gnt_q),
    .lock_mask (lock_mask),
    .sel       (sel),
    .valid     (sel_valid)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_gnt_d  = last_gnt_q;
    wen_d       = wen_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wen_d   = 1'b0;
    m0_gnt_d    = 1'b0;
    m1_gnt_d    = 1'b0;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
`ifdef SYS_ARB_LOCK_EN
    lock_d      = lock_q;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef SYS_ARB_LOCK_EN
        lock_d = lock_hold;
`endif
        if (sel_valid) begin
          if (sel == MID_M1) begin
            bus_addr_d  = m1_addr;
            bus_wdata_d = m1_wdata;
            wen_d       = m1_wen;
            m1_gnt_d    = 1'b1;
`ifdef SYS_ARB_LOCK_EN
            lock_d      = m1_lock;
`endif
          end else begin
            bus_addr_d  = m0_addr;
            bus_wdata_d = m0_wdata;
            wen_d       = m0_wen;
            m0_gnt_d    = 1'b1;
`ifdef SYS_ARB_LOCK_EN
            lock_d      = m0_lock;
`endif
          end
          bus_wen_d  = (sel == MID_M1) ? m1_wen : m0_wen;
          owner_d    = sel;
          last_gnt_d = sel;
          cnt_d      = 2'd0;
          state_d    = ST_ADDR;
        end
      end

      ST_ADDR: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_CNT) begin
          if (owner_q == MID_M1) begin
            m1_rvalid_d = 1'b1;
            m1_rdata_d  = wen_q ? '0 : bus_rdata;
          end else begin
            m0_rvalid_d = 1'b1;
            m0_rdata_d  = wen_q ? '0 : bus_rdata;
          end
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      owner_q     <= MID_M0;
      last_gnt_q  <= MID_M1;
      wen_q       <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wen_q   <= 1'b0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
`ifdef SYS_ARB_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_gnt_q  <= last_gnt_d;
      wen_q       <= wen_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wen_q   <= bus_wen_d;
      m0_gnt_q    <= m0_gnt_d;
      m1_gnt_q    <= m1_gnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
`ifdef SYS_ARB_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign m0_gnt    = m0_gnt_q;
  assign m1_gnt    = m1_gnt_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wen   = bus_wen_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb/tb_sys_bus_arbiter.sv - self-checking bench for sys_bus_arbiter
module tb_sys_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        m0_req[2], m0_wen[2], m0_gnt[2], m0_rvalid[2];
  logic [31:0] m0_addr[2], m0_wdata[2], m0_rdata[2];
  logic        m1_req[2], m1_wen[2], m1_gnt[2], m1_rvalid[2];
  logic [31:0] m1_addr[2], m1_wdata[2], m1_rdata[2];
  logic [31:0] bus_addr[2], bus_wdata[2], bus_rdata[2];
  logic        bus_wen[2];
`ifdef SYS_ARB_LOCK_EN
  logic        m0_lock[2], m1_lock[2];
`endif

  sys_bus_arbiter #(.RD_LAT(1), .AW(32), .DW(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req[0]), .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]), .m0_wen(m0_wen[0]),
    .m0_gnt(m0_gnt[0]), .m0_rvalid(m0_rvalid[0]), .m0_rdata(m0_rdata[0]),
    .m1_req(m1_req[0]), .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]), .m1_wen(m1_wen[0]),
    .m1_gnt(m1_gnt[0]), .m1_rvalid(m1_rvalid[0]), .m1_rdata(m1_rdata[0]),
`ifdef SYS_ARB_LOCK_EN
    .m0_lock(m0_lock[0]), .m1_lock(m1_lock[0]),
`endif
    .bus_addr(bus_addr[0]), .bus_wdata(bus_wdata[0]), .bus_wen(bus_wen[0]),
    .bus_rdata(bus_rdata[0])
  );

  sys_bus_arbiter #(.RD_LAT(3), .AW(32), .DW(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req[1]), .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]), .m0_wen(m0_wen[1]),
    .m0_gnt(m0_gnt[1]), .m0_rvalid(m0_rvalid[1]), .m0_rdata(m0_rdata[1]),
    .m1_req(m1_req[1]), .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]), .m1_wen(m1_wen[1]),
    .m1_gnt(m1_gnt[1]), .m1_rvalid(m1_rvalid[1]), .m1_rdata(m1_rdata[1]),
`ifdef SYS_ARB_LOCK_EN
    .m0_lock(m0_lock[1]), .m1_lock(m1_lock[1]),
`endif
    .bus_addr(bus_addr[1]), .bus_wdata(bus_wdata[1]), .bus_wen(bus_wen[1]),
    .bus_rdata(bus_rdata[1])
  );

  // Transaction-level reference: who won last, what each master last received.
  int          lat[2] = '{1, 3};
  int          last_w[2];
  logic [31:0] hist[2][2];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input int i, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL dut%0d %s: observed 0x%0h expected 0x%0h", i, tag, obs, exp);
    end
  endtask

  function automatic logic gnt_of(input int i, input int m);
    return (m == 1) ? m1_gnt[i] : m0_gnt[i];
  endfunction

  function automatic logic rv_of(input int i, input int m);
    return (m == 1) ? m1_rvalid[i] : m0_rvalid[i];
  endfunction

  function automatic logic [31:0] rd_of(input int i, input int m);
    return (m == 1) ? m1_rdata[i] : m0_rdata[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      last_w[i]  = 1;
      hist[i][0] = '0;
      hist[i][1] = '0;
    end
  endtask

  task automatic reset_chk(input int i);
    chk(i, "rst_m0_gnt", m0_gnt[i], 0);
    chk(i, "rst_m1_gnt", m1_gnt[i], 0);
    chk(i, "rst_m0_rvalid", m0_rvalid[i], 0);
    chk(i, "rst_m1_rvalid", m1_rvalid[i], 0);
    chk(i, "rst_m0_rdata", m0_rdata[i], 0);
    chk(i, "rst_m1_rdata", m1_rdata[i], 0);
    chk(i, "rst_bus_addr", bus_addr[i], 0);
    chk(i, "rst_bus_wdata", bus_wdata[i], 0);
    chk(i, "rst_bus_wen", bus_wen[i], 0);
  endtask

  // One arbitration round, entered and left at a falling edge of an IDLE cycle.
  // force_w >= 0 overrides the round-robin choice when both request (bus lock).
  task automatic round(input int i, input bit r0, input bit r1, input bit w0, input bit w1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] rd, input int force_w);
    int          w;
    logic [31:0] ea, ed;
    bit          ew;
    m0_req[i] = r0; m0_wen[i] = w0; m0_addr[i] = a0; m0_wdata[i] = d0;
    m1_req[i] = r1; m1_wen[i] = w1; m1_addr[i] = a1; m1_wdata[i] = d1;
    bus_rdata[i] = $urandom;
    if (!r0 && !r1)     w = -1;
    else if (r0 && r1)  w = (force_w >= 0) ? force_w : 1 - last_w[i];
    else                w = r1 ? 1 : 0;
    @(posedge clk); @(negedge clk);
    if (w < 0) begin
      chk(i, "idle_m0_gnt", m0_gnt[i], 0);
      chk(i, "idle_m1_gnt", m1_gnt[i], 0);
      chk(i, "idle_bus_wen", bus_wen[i], 0);
      return;
    end
    ea = (w == 1) ? a1 : a0;
    ed = (w == 1) ? d1 : d0;
    ew = (w == 1) ? w1 : w0;
    chk(i, "gnt_winner", gnt_of(i, w), 1);
    chk(i, "gnt_loser", gnt_of(i, 1 - w), 0);
    chk(i, "bus_addr", bus_addr[i], ea);
    chk(i, "bus_wdata", bus_wdata[i], ed);
    chk(i, "bus_wen_first", bus_wen[i], 32'(ew));
    chk(i, "rvalid_early", rv_of(i, w), 0);
    // Requests and inputs change after the grant; the latched values must hold.
    m0_req[i] = 0; m1_req[i] = 0;
    m0_addr[i] = $urandom; m1_addr[i] = $urandom;
    m0_wen[i] = ~m0_wen[i]; m1_wen[i] = ~m1_wen[i];
    for (int j = 1; j < lat[i]; j++) begin
      @(posedge clk); @(negedge clk);
      chk(i, "gnt_second", gnt_of(i, w), 0);
      chk(i, "bus_wen_later", bus_wen[i], 0);
      chk(i, "bus_addr_stable", bus_addr[i], ea);
      chk(i, "rvalid_mid", rv_of(i, w), 0);
    end
    bus_rdata[i] = rd;
    @(posedge clk); @(negedge clk);
    chk(i, "rvalid_winner", rv_of(i, w), 1);
    chk(i, "rdata_winner", rd_of(i, w), ew ? 32'h0 : rd);
    chk(i, "rvalid_loser", rv_of(i, 1 - w), 0);
    chk(i, "rdata_loser", rd_of(i, 1 - w), hist[i][1 - w]);
    chk(i, "gnt_at_rvalid", gnt_of(i, w), 0);
    hist[i][w] = ew ? 32'h0 : rd;
    last_w[i]  = w;
    bus_rdata[i] = $urandom;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m0_req[i] = 0; m0_wen[i] = 0; m0_addr[i] = '0; m0_wdata[i] = '0;
      m1_req[i] = 0; m1_wen[i] = 0; m1_addr[i] = '0; m1_wdata[i] = '0;
      bus_rdata[i] = '0;
`ifdef SYS_ARB_LOCK_EN
      m0_lock[i] = 0; m1_lock[i] = 0;
`endif
    end
    model_reset();
    repeat (3) @(negedge clk);
    reset_chk(0);
    reset_chk(1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read, then single write, RD_LAT=1.
    round(0, 1, 0, 0, 0, 32'h1000_0004, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, -1);
    round(0, 0, 1, 0, 1, 32'h0, 32'h3000_0000, 32'h0, 32'h41, 32'h5555_AAAA, -1);

    // Contention, both requesting back-to-back: m0, m1, m0, m1.
    for (int k = 0; k < 4; k++)
      round(0, 1, 1, 0, 0, $urandom, $urandom, $urandom, $urandom, $urandom, -1);

    // RD_LAT=3 read.
    round(1, 1, 0, 0, 0, 32'h1000_0010, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D, -1);

    // Reset during the second ADDR cycle of an RD_LAT=3 read.
    m0_req[1] = 1; m0_wen[1] = 0; m0_addr[1] = 32'h2000_0008;
    @(posedge clk); @(negedge clk);
    chk(1, "midrst_gnt", m0_gnt[1], 1);
    m0_req[1] = 0;
    bus_rdata[1] = 32'h1234_5678;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    reset_chk(0);
    reset_chk(1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      chk(1, "post_rst_m0_rvalid", m0_rvalid[1], 0);
      chk(1, "post_rst_m1_rvalid", m1_rvalid[1], 0);
      chk(1, "post_rst_bus_wen", bus_wen[1], 0);
    end
    round(1, 1, 0, 1, 0, 32'h2000_0000, 32'h0, 32'h77, 32'h0, $urandom, -1);

`ifdef SYS_ARB_LOCK_EN
    // m1 locks the bus for three transfers while m0 waits.
    m1_lock[0] = 1;
    round(0, 0, 1, 0, 0, $urandom, $urandom, $urandom, $urandom, $urandom, -1);
    round(0, 1, 1, 0, 0, $urandom, $urandom, $urandom, $urandom, $urandom, 1);
    round(0, 1, 1, 0, 0, $urandom, $urandom, $urandom, $urandom, $urandom, 1);
    m1_lock[0] = 0;
    round(0, 1, 1, 0, 0, $urandom, $urandom, $urandom, $urandom, $urandom, 0);
`endif

    // Randomized rounds on both latencies.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 40; k++) begin
        round(i, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom, $urandom, $urandom, $urandom, $urandom, -1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
